spi_ram_ctrl: RTL and testbench
===============================

Name: spi_ram_ctrl

Overview:
- Single-port RAM with command decoder, directly downstream of the SPI slave.
- Consumes the slave's 10-bit received word (rx_data/rx_valid) and returns read bytes on tx_data/tx_valid, which the slave shifts out on MISO.
- din[9:8] is the command and din[7:0] is the address or data payload.
- Separate write and read address pointers, each auto-incrementing, so one address command can be followed by burst accesses.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words; legal range 2..256.
- ADDR_SIZE, 8, pointer width; fixed at 8 because the payload is 8 bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  10  received word from the SPI slave: [9:8] command, [7:0] payload.
- rx_valid  input  1  din valid; may stay high for many cycles.
- dout  output  8  read data to the SPI slave.
- tx_valid  output  1  dout valid; held high while the slave serialises.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: dout=0, tx_valid=0, err=0, wr_ptr=0, rd_ptr=0, wr_ok=0, rd_ok=0, rx_valid_q=0.
- Memory array is not reset; contents survive reset.
- Reset mid-read drops tx_valid immediately and the pending read is lost.
- Command acceptance:
  - acc = rx_valid & ~rx_valid_q, where rx_valid_q is rx_valid registered every cycle.
  - Exactly one command is decoded per rx_valid rising edge; a held-high rx_valid is ignored after the first cycle.
  - rx_valid already high at reset release counts as an edge.
- Commands, all acted on at the clock edge where acc=1:
  - 00 WR_ADDR: if payload < MEM_DEPTH, then wr_ptr <= payload and wr_ok <= 1. Otherwise err <= 1 and wr_ptr/wr_ok are unchanged.
  - 01 WR_DATA: if wr_ok, then mem[wr_ptr] <= payload and wr_ptr advances. Otherwise err <= 1 and there is no write.
  - 10 RD_ADDR: if payload < MEM_DEPTH, then rd_ptr <= payload and rd_ok <= 1. Otherwise err <= 1.
  - 11 RD_DATA: if rd_ok, then dout <= mem[rd_ptr], tx_valid <= 1, and rd_ptr advances. Otherwise err <= 1, and tx_valid and dout are unchanged. The payload is ignored.
- Pointer advance: ptr == MEM_DEPTH-1 wraps to 0, otherwise ptr+1. No other arithmetic; all widths are 8 bits.
- Latency:
  - A write is visible to any RD_DATA accepted on a later edge.
  - dout and tx_valid appear 1 cycle after the acc edge (registered read).
- tx_valid:
  - Set by an accepted RD_DATA.
  - Cleared on the falling edge of rx_valid (rx_valid_q & ~rx_valid), i.e. when the slave ends the read-data frame.
  - If set and clear coincide, set wins.
  - RD_DATA while tx_valid=1 updates dout and keeps tx_valid=1.
- dout holds its last value after tx_valid falls.
- wr_ok and rd_ok stay set until reset; pointer wrap does not clear them.
- Reading an address that was never written returns the array contents, which are undefined in RTL; the bench must write before reading.
- err is sticky and cleared only by rst_n.

Decomposition:
- Package spi_ram_pkg:
  - cmd_e enum: CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - Localparams CMD_W=2 and PAYLOAD_W=8.
  - Default MEM_DEPTH.
- One natural sub-module, spi_ram_array: synchronous write, registered read, no reset, parameterised by MEM_DEPTH.
- Decode, pointers, flags and tx_valid control live in the top.

Test Plan:
- Reset, then WR_ADDR 0x10, WR_DATA 0xA5, WR_DATA 0x3C, RD_ADDR 0x10, RD_DATA twice, each with rx_valid held 5 cycles -> dout=0xA5 then 0x3C; tx_valid high 1 cycle after each RD_DATA acc and low after each rx_valid fall; err=0.
- rx_valid held high 20 cycles with WR_DATA 0x55 at wr_ptr=0x20 -> exactly one write, so wr_ptr=0x21; a read of 0x21 returns the prior content and is unchanged by the repeat cycles.
- MEM_DEPTH=256: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22; then RD_ADDR 0xFF, RD_DATA x2 -> reads 0x11 then 0x22, proving wrap to address 0.
- Error cases, each from reset:
  - RD_DATA with no prior RD_ADDR -> err=1, tx_valid=0.
  - WR_DATA with no prior WR_ADDR -> err=1, no write.
  - With MEM_DEPTH=128, RD_ADDR 0x80 -> err=1, rd_ok stays 0.
- rst_n pulsed low for 1 cycle while tx_valid=1 -> tx_valid=0 and dout=0 asynchronously, pointers 0; previously written data is still readable after a new RD_ADDR.
- Back-to-back RD_DATA with rx_valid low for only 1 cycle between them -> both accepted; tx_valid toggles low for 1 cycle, then high with the next byte.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - shared command encoding, widths and pointer helper for spi_ram_ctrl
package spi_ram_pkg;

    localparam int CMD_W             = 2;
    localparam int PAYLOAD_W         = 8;
    localparam int DEFAULT_MEM_DEPTH = 256;

    typedef enum logic [CMD_W-1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    // Advance a pointer, wrapping at the last legal word of a depth-word array.
    function automatic logic [PAYLOAD_W-1:0] ptr_next(input logic [PAYLOAD_W-1:0] ptr,
                                                      input int depth);
        logic [PAYLOAD_W-1:0] last;
        last = PAYLOAD_W'(depth - 1);
        return (ptr == last) ? '0 : ptr + 1'b1;
    endfunction

endpackage

// File: rtl/spi_ram_ctrl_array.sv
// rtl/spi_ram_ctrl_array.sv - single-port storage with synchronous write and registered read, no reset
module spi_ram_array
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [PAYLOAD_W-1:0] waddr,
    input  logic [PAYLOAD_W-1:0] wdata,
    input  logic                 re,
    input  logic [PAYLOAD_W-1:0] raddr,
    output logic [PAYLOAD_W-1:0] rdata
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [PAYLOAD_W-1:0] mem [MEM_DEPTH];
    logic [PAYLOAD_W-1:0] rdata_q;

    // Addresses are range-checked by the decoder, so only the low AW bits matter.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr[AW-1:0]] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr[AW-1:0]];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - SPI-slave-facing command decoder with burst pointers around spi_ram_array
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
    parameter int ADDR_SIZE = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CMD_W+PAYLOAD_W-1:0]    din,
    input  logic                          rx_valid,
    output logic [PAYLOAD_W-1:0]          dout,
    output logic                          tx_valid,
    output logic                          err
);

    logic                 rx_valid_q, rx_valid_d;
    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic                 wr_ok_q, wr_ok_d;
    logic                 rd_ok_q, rd_ok_d;
    logic                 err_q, err_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 rd_loaded_q, rd_loaded_d;

    logic                 acc, rx_fall, in_range;
    logic                 mem_we, mem_re;
    cmd_e                 cmd;
    logic [PAYLOAD_W-1:0] payload;
    logic [PAYLOAD_W-1:0] rdata;

    always_comb begin
        cmd         = cmd_e'(din[CMD_W+PAYLOAD_W-1:PAYLOAD_W]);
        payload     = din[PAYLOAD_W-1:0];
        acc         = rx_valid & ~rx_valid_q;
        rx_fall     = rx_valid_q & ~rx_valid;
        in_range    = int'(payload) < MEM_DEPTH;

        rx_valid_d  = rx_valid;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ok_d     = wr_ok_q;
        rd_ok_d     = rd_ok_q;
        err_d       = err_q;
        rd_loaded_d = rd_loaded_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        tx_valid_d  = rx_fall ? 1'b0 : tx_valid_q;

        if (acc) begin
            unique case (cmd)
                CMD_WR_ADDR: begin
                    if (in_range) begin
                        wr_ptr_d = payload;
                        wr_ok_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_WR_DATA: begin
                    if (wr_ok_q) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = ptr_next(wr_ptr_q, MEM_DEPTH);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_RD_ADDR: begin
                    if (in_range) begin
                        rd_ptr_d = payload;
                        rd_ok_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_RD_DATA: begin
                    // Assigned after the fall-clear so a coincident set wins.
                    if (rd_ok_q) begin
                        mem_re      = 1'b1;
                        rd_loaded_d = 1'b1;
                        tx_valid_d  = 1'b1;
                        rd_ptr_d    = ptr_next(rd_ptr_q, MEM_DEPTH);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wr_ok_q     <= 1'b0;
            rd_ok_q     <= 1'b0;
            err_q       <= 1'b0;
            tx_valid_q  <= 1'b0;
            rd_loaded_q <= 1'b0;
        end else begin
            rx_valid_q  <= rx_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ok_q     <= wr_ok_d;
            rd_ok_q     <= rd_ok_d;
            err_q       <= err_d;
            tx_valid_q  <= tx_valid_d;
            rd_loaded_q <= rd_loaded_d;
        end
    end

    spi_ram_array #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (payload),
        .re    (mem_re),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    // The array register has no reset; masking it yields dout=0 from reset until the first read.
    assign dout     = rd_loaded_q ? rdata : '0;
    assign tx_valid = tx_valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb/tb_spi_ram_ctrl.sv - scoreboard bench for spi_ram_ctrl with a 256-deep and a 128-deep instance
module tb_spi_ram_ctrl;
    import spi_ram_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] dout, dout_s;
    logic       tx_valid, tx_valid_s;
    logic       err, err_s;

    int passed = 0;
    int total  = 0;
    logic [7:0] exp_q [$];
    logic       tx_prev = 1'b0;
    logic       tx_s_seen = 1'b0;

    always #5 clk = ~clk;

    spi_ram_ctrl #(.MEM_DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout), .tx_valid(tx_valid), .err(err)
    );

    spi_ram_ctrl #(.MEM_DEPTH(128)) dut_s (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout_s), .tx_valid(tx_valid_s), .err(err_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Every rising tx_valid presents one byte that must match the next expected read.
    always @(negedge clk) begin
        if (tx_valid && !tx_prev) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_read: got 0x%0h expected no read at %0t", dout, $time);
            end else begin
                check("read_data", {24'd0, dout}, {24'd0, exp_q.pop_front()});
            end
        end
        tx_prev = tx_valid;
        if (tx_valid_s) tx_s_seen = 1'b1;
    end

    task automatic do_reset();
        rst_n = 1'b0;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", {24'd0, dout}, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_err_s", {31'd0, err_s}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; holds rx_valid for hold edges then low for gap edges.
    task automatic send(input cmd_e cmd, input logic [7:0] pl, input int hold,
                        input int gap, input bit chk_tx);
        din = {cmd, pl};
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        if (chk_tx) check("tx_after_acc", {31'd0, tx_valid}, 32'd1);
        repeat (hold - 1) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        if (chk_tx) check("tx_after_fall", {31'd0, tx_valid}, 32'd0);
        repeat (gap - 1) @(posedge clk);
        if (gap > 1) #1;
    endtask

    initial begin
        do_reset();

        // basic write burst then read burst
        send(CMD_WR_ADDR, 8'h10, 5, 2, 0);
        send(CMD_WR_DATA, 8'hA5, 5, 2, 0);
        send(CMD_WR_DATA, 8'h3C, 5, 2, 0);
        send(CMD_RD_ADDR, 8'h10, 5, 2, 0);
        exp_q.push_back(8'hA5);
        send(CMD_RD_DATA, 8'h00, 5, 2, 1);
        exp_q.push_back(8'h3C);
        send(CMD_RD_DATA, 8'h00, 5, 2, 1);
        check("basic_err", {31'd0, err}, 32'd0);

        // long-held rx_valid writes exactly once
        send(CMD_WR_ADDR, 8'h21, 3, 2, 0);
        send(CMD_WR_DATA, 8'h77, 3, 2, 0);
        send(CMD_WR_ADDR, 8'h20, 3, 2, 0);
        send(CMD_WR_DATA, 8'h55, 20, 2, 0);
        send(CMD_RD_ADDR, 8'h20, 3, 2, 0);
        exp_q.push_back(8'h55);
        send(CMD_RD_DATA, 8'h00, 3, 2, 0);
        exp_q.push_back(8'h77);
        send(CMD_RD_DATA, 8'h00, 3, 2, 0);
        send(CMD_WR_DATA, 8'h99, 3, 2, 0);
        send(CMD_RD_ADDR, 8'h21, 3, 2, 0);
        exp_q.push_back(8'h99);
        send(CMD_RD_DATA, 8'h00, 3, 2, 0);
        check("hold_err", {31'd0, err}, 32'd0);

        // pointer wrap at the top of a 256-word array
        send(CMD_WR_ADDR, 8'hFF, 3, 2, 0);
        send(CMD_WR_DATA, 8'h11, 3, 2, 0);
        send(CMD_WR_DATA, 8'h22, 3, 2, 0);
        send(CMD_RD_ADDR, 8'hFF, 3, 2, 0);
        exp_q.push_back(8'h11);
        send(CMD_RD_DATA, 8'h00, 3, 2, 0);
        exp_q.push_back(8'h22);
        send(CMD_RD_DATA, 8'h00, 3, 2, 0);
        check("wrap_err", {31'd0, err}, 32'd0);
        send(CMD_WR_ADDR, 8'h80, 3, 2, 0);
        send(CMD_WR_DATA, 8'hC3, 3, 2, 0);

        // RD_DATA without RD_ADDR
        do_reset();
        send(CMD_RD_DATA, 8'h00, 3, 2, 0);
        check("rd_noaddr_err", {31'd0, err}, 32'd1);
        check("rd_noaddr_tx", {31'd0, tx_valid}, 32'd0);

        // WR_DATA without WR_ADDR must not touch address 0 (holds 0x22)
        do_reset();
        send(CMD_WR_DATA, 8'h42, 3, 2, 0);
        check("wr_noaddr_err", {31'd0, err}, 32'd1);
        do_reset();
        send(CMD_RD_ADDR, 8'h00, 3, 2, 0);
        exp_q.push_back(8'h22);
        send(CMD_RD_DATA, 8'h00, 3, 2, 0);
        check("wr_noaddr_clean", {31'd0, err}, 32'd0);

        // 0x80 is legal for 256 words but out of range for 128 words
        do_reset();
        tx_s_seen = 1'b0;
        send(CMD_RD_ADDR, 8'h80, 3, 2, 0);
        check("range_err_256", {31'd0, err}, 32'd0);
        check("range_err_128", {31'd0, err_s}, 32'd1);
        exp_q.push_back(8'hC3);
        send(CMD_RD_DATA, 8'h00, 3, 2, 0);
        check("range_tx_128", {31'd0, tx_s_seen}, 32'd0);

        // asynchronous reset during a read
        do_reset();
        send(CMD_RD_ADDR, 8'h10, 3, 2, 0);
        din = {CMD_RD_DATA, 8'h00};
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        check("midrd_tx_before", {31'd0, tx_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrd_tx_async", {31'd0, tx_valid}, 32'd0);
        check("midrd_dout_async", {24'd0, dout}, 32'd0);
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(CMD_RD_ADDR, 8'h10, 3, 2, 0);
        exp_q.push_back(8'hA5);
        send(CMD_RD_DATA, 8'h00, 3, 2, 0);

        // back-to-back reads with a single idle cycle between frames
        send(CMD_RD_ADDR, 8'h10, 3, 2, 0);
        exp_q.push_back(8'hA5);
        send(CMD_RD_DATA, 8'h00, 3, 1, 1);
        exp_q.push_back(8'h3C);
        send(CMD_RD_DATA, 8'h00, 3, 2, 1);
        check("b2b_err", {31'd0, err}, 32'd0);

        repeat (2) @(posedge clk);
        check("reads_outstanding", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
